// File: rtl/decode_stage.sv
// Registered RV32I(M) instruction-decode stage. Decodes the incoming word,
// flags illegal encodings and holds decoded bundles in a 2-entry skid FIFO.
module decode_stage #(
  parameter int ENABLE_M = 0,
  parameter int ALU_OP_W = 4 + ENABLE_M
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                flush_in,
  input  logic                instr_valid_in,
  output logic                instr_ready_out,
  input  logic [31:0]         instr_in,
  input  logic [31:0]         pc_in,
  output logic                dec_valid_out,
  input  logic                dec_ready_in,
  output logic [31:0]         pc_out,
  output logic [31:0]         instr_out,
  output logic [4:0]          rs1_out,
  output logic [4:0]          rs2_out,
  output logic [4:0]          rd_out,
  output logic [ALU_OP_W-1:0] alu_opcode_out,
  output logic [2:0]          imm_type_out,
  output logic [2:0]          wb_mux_sel_out,
  output logic                alu_src_out,
  output logic                iadder_src_out,
  output logic [1:0]          load_size_out,
  output logic                load_unsigned_out,
  output logic                mem_wr_req_out,
  output logic                wr_en_out,
  output logic                is_system_out,
  output logic                illegal_out
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          imm_type;
    logic [2:0]          wb_sel;
    logic                iadder_src;
    logic                mem_wr;
    logic                wr_en;
    logic                is_system;
    logic                illegal;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       m_op;
  logic       push;
  logic       pop;
  logic [1:0] count;
  bundle_t    dec;
  bundle_t    head;
  bundle_t    tail;

  assign opcode = instr_in[6:0];
  assign func3  = instr_in[14:12];
  assign func7  = instr_in[31:25];
  assign m_op   = (ENABLE_M != 0) && (func7 == 7'b0000001);

  always_comb begin
    dec              = '0;
    dec.pc           = pc_in;
    dec.instr        = instr_in;
    dec.alu_op[2:0]  = func3;
    case (opcode)
      OPC_LOAD: begin
        dec.imm_type   = 3'd1;
        dec.wb_sel     = 3'd1;
        dec.iadder_src = 1'b1;
        dec.wr_en      = 1'b1;
        dec.illegal    = (func3 == 3'b011) || (func3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.imm_type   = 3'd2;
        dec.iadder_src = 1'b1;
        dec.mem_wr     = 1'b1;
        dec.illegal    = (func3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        dec.imm_type  = 3'd1;
        dec.wr_en     = 1'b1;
        dec.alu_op[3] = (func3 == 3'b101) & instr_in[30];
        dec.illegal   = ((func3 == 3'b001) && (func7 != 7'b0)) ||
                        ((func3 == 3'b101) && (func7 != 7'b0) && (func7 != 7'b0100000));
      end
      OPC_OP: begin
        dec.wr_en = 1'b1;
        // m_op can only be set when the extra M bit exists, so the top index is bit 4 here
        if (m_op) dec.alu_op[ALU_OP_W-1] = 1'b1;
        else      dec.alu_op[3]          = instr_in[30];
        dec.illegal = !((func7 == 7'b0) || (func7 == 7'b0100000) || m_op) ||
                      ((func7 == 7'b0100000) && (func3 != 3'b000) && (func3 != 3'b101));
      end
      OPC_LUI: begin
        dec.imm_type = 3'd4;
        dec.wb_sel   = 3'd2;
        dec.wr_en    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm_type = 3'd4;
        dec.wb_sel   = 3'd3;
        dec.wr_en    = 1'b1;
      end
      OPC_JAL: begin
        dec.imm_type = 3'd5;
        dec.wb_sel   = 3'd4;
        dec.wr_en    = 1'b1;
      end
      OPC_JALR: begin
        dec.imm_type   = 3'd1;
        dec.wb_sel     = 3'd4;
        dec.iadder_src = 1'b1;
        dec.wr_en      = 1'b1;
        dec.illegal    = (func3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.imm_type = 3'd3;
        dec.illegal  = (func3[2:1] == 2'b01);
      end
      OPC_MISC, OPC_SYSTEM: dec.is_system = 1'b1;
      default:              dec.illegal   = 1'b1;
    endcase
    // Illegal bundles still flow downstream but must not cause side effects
    if (dec.illegal) begin
      dec.wr_en     = 1'b0;
      dec.mem_wr    = 1'b0;
      dec.is_system = 1'b0;
    end
  end

  assign instr_ready_out = (count < 2'd2) & ~rst_in;
  assign dec_valid_out   = (count != 2'd0);
  assign push            = instr_valid_in & instr_ready_out & ~flush_in;
  assign pop             = dec_valid_out & dec_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush_in) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: if (push) begin
          head  <= dec;
          count <= 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            head <= dec;
          end else if (push) begin
            tail  <= dec;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: if (pop) begin
          head  <= tail;
          count <= 2'd1;
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign pc_out            = head.pc;
  assign instr_out         = head.instr;
  assign rs1_out           = head.instr[19:15];
  assign rs2_out           = head.instr[24:20];
  assign rd_out            = head.instr[11:7];
  assign alu_opcode_out    = head.alu_op;
  assign imm_type_out      = head.imm_type;
  assign wb_mux_sel_out    = head.wb_sel;
  assign alu_src_out       = head.instr[5];
  assign iadder_src_out    = head.iadder_src;
  assign load_size_out     = head.instr[13:12];
  assign load_unsigned_out = head.instr[14];
  assign mem_wr_req_out    = head.mem_wr;
  assign wr_en_out         = head.wr_en;
  assign is_system_out     = head.is_system;
  assign illegal_out       = head.illegal;

endmodule
